// File: rtl/sram_data_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module   : sram_data_axi_bridge
// Purpose  : SRAM-like data port to single-outstanding, single-beat AXI3 master
// Revision : 1.0
// ============================================================================
module sram_data_axi_bridge #(
  parameter logic [3:0] RD_ID = 4'd0,
  parameter logic [3:0] WR_ID = 4'd1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_AR   = 3'd1;
  localparam logic [2:0] S_RD_R    = 3'd2;
  localparam logic [2:0] S_WR_AW_W = 3'd3;
  localparam logic [2:0] S_WR_B    = 3'd4;

  logic [2:0]  r_state;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_aw_done;
  logic        r_w_done;
  logic        r_data_ok;

  logic        w_aw_hs;
  logic        w_w_hs;
  logic [3:0]  w_strb;

  assign w_aw_hs = awvalid && awready;
  assign w_w_hs  = wvalid && wready;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_size    <= 2'd0;
      r_addr    <= 32'd0;
      r_wdata   <= 32'd0;
      r_rdata   <= 32'd0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_data_ok <= 1'b0;
    end else begin
      r_data_ok <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_aw_done <= 1'b0;
          r_w_done  <= 1'b0;
          if (data_req) begin
            r_size  <= data_size;
            r_addr  <= data_addr;
            r_wdata <= data_wdata;
            r_state <= data_wr ? S_WR_AW_W : S_RD_AR;
          end
        end
        S_RD_AR: begin
          if (arready) r_state <= S_RD_R;
        end
        S_RD_R: begin
          if (rvalid) begin
            r_rdata   <= rdata;
            r_data_ok <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        S_WR_AW_W: begin
          // address and data channels complete independently, in any order
          if (w_aw_hs) r_aw_done <= 1'b1;
          if (w_w_hs)  r_w_done  <= 1'b1;
          if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) r_state <= S_WR_B;
        end
        S_WR_B: begin
          if (bvalid) begin
            r_data_ok <= 1'b1;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_strb = 4'b1111;
    case (r_size)
      2'd0:    w_strb = 4'b0001 << r_addr[1:0];
      2'd1:    w_strb = r_addr[1] ? 4'b1100 : 4'b0011;
      default: w_strb = 4'b1111;
    endcase
  end

  assign data_addr_ok = (r_state == S_IDLE);
  assign data_data_ok = r_data_ok;
  assign data_rdata   = r_rdata;

  assign arid    = RD_ID;
  assign araddr  = r_addr;
  assign arsize  = {1'b0, r_size};
  assign arvalid = (r_state == S_RD_AR);
  assign rready  = (r_state == S_RD_R);

  assign awid    = WR_ID;
  assign awaddr  = r_addr;
  assign awsize  = {1'b0, r_size};
  assign awvalid = (r_state == S_WR_AW_W) && !r_aw_done;
  assign wdata   = r_wdata;
  assign wstrb   = w_strb;
  assign wvalid  = (r_state == S_WR_AW_W) && !r_w_done;
  assign bready  = (r_state == S_WR_B);

endmodule
`default_nettype wire

// File: tb/tb_sram_data_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_data_axi_bridge
// Purpose  : scoreboard bench for sram_data_axi_bridge with a delay-programmable AXI slave
// Revision : 1.0
// ============================================================================
module tb_sram_data_axi_bridge;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        data_req = 1'b0;
  logic        data_wr = 1'b0;
  logic [1:0]  data_size = 2'd0;
  logic [31:0] data_addr = 32'd0;
  logic [31:0] data_wdata = 32'd0;
  logic [31:0] data_rdata;
  logic        data_addr_ok, data_data_ok;
  logic [3:0]  arid, awid;
  logic [31:0] araddr, awaddr, wdata;
  logic [2:0]  arsize, awsize;
  logic        arvalid, rready, awvalid, wvalid, bready;
  logic        arready = 1'b0, rvalid = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [31:0] rdata = 32'd0;
  logic [3:0]  wstrb;

  sram_data_axi_bridge #(.RD_ID(4'd0), .WR_ID(4'd1)) dut (
    .clk(clk), .resetn(resetn),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int busy_until = 0;
  bit mon_en  = 1'b0;

  // slave latency knobs (cycles of valid before ready/response)
  int ad = 0, rd = 0, awd = 0, wd = 0, bd = 0;
  logic [31:0] rd_val = 32'd0;
  logic [31:0] last_rd = 32'd0;

  logic [34:0] exp_ar[$];
  logic [34:0] exp_aw[$];
  logic [35:0] exp_w[$];
  logic [31:0] exp_ok_data[$];
  int          exp_ok_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_evt(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
  endtask

  // AXI slave: inputs change 1 time unit after the rising edge
  initial begin
    int ac = 0, rc = 0, awc = 0, wc = 0, bc = 0;
    forever begin
      @(posedge clk); #1;
      if (arvalid) begin arready = (ac >= ad); ac++; end else begin arready = 0; ac = 0; end
      if (rready)  begin rvalid  = (rc == rd); rc++; end else begin rvalid  = 0; rc = 0; end
      if (awvalid) begin awready = (awc >= awd); awc++; end else begin awready = 0; awc = 0; end
      if (wvalid)  begin wready  = (wc >= wd); wc++; end else begin wready  = 0; wc = 0; end
      if (bready)  begin bvalid  = (bc == bd); bc++; end else begin bvalid  = 0; bc = 0; end
      rdata = rd_val;
    end
  end

  // monitor / scoreboard
  initial begin
    bit pend_ar = 0, pend_aw = 0, pend_w = 0, aw_seen = 0, w_seen = 0;
    logic [34:0] prev_ar = '0, prev_aw = '0;
    logic [35:0] prev_w = '0;
    logic [34:0] e35;
    logic [35:0] e36;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (!resetn) begin
          pend_ar = 0; pend_aw = 0; pend_w = 0; aw_seen = 0; w_seen = 0;
        end else begin
          if (pend_ar) begin
            chk("ar_hold_valid", {31'd0, arvalid}, 32'd1);
            chk("ar_hold_addr", araddr, prev_ar[34:3]);
            chk("ar_hold_size", {29'd0, arsize}, {29'd0, prev_ar[2:0]});
          end
          if (pend_aw) begin
            chk("aw_hold_valid", {31'd0, awvalid}, 32'd1);
            chk("aw_hold_addr", awaddr, prev_aw[34:3]);
          end
          if (pend_w) begin
            chk("w_hold_valid", {31'd0, wvalid}, 32'd1);
            chk("w_hold_data", wdata, prev_w[35:4]);
          end
          if (arvalid && arready) begin
            if (exp_ar.size() == 0) fail_evt("ar_handshake");
            else begin
              e35 = exp_ar.pop_front();
              chk("araddr", araddr, e35[34:3]);
              chk("arsize", {29'd0, arsize}, {29'd0, e35[2:0]});
              chk("arid", {28'd0, arid}, 32'd0);
            end
          end
          if (awvalid && awready) begin
            aw_seen = 1;
            if (exp_aw.size() == 0) fail_evt("aw_handshake");
            else begin
              e35 = exp_aw.pop_front();
              chk("awaddr", awaddr, e35[34:3]);
              chk("awsize", {29'd0, awsize}, {29'd0, e35[2:0]});
              chk("awid", {28'd0, awid}, 32'd1);
            end
          end
          if (wvalid && wready) begin
            w_seen = 1;
            if (exp_w.size() == 0) fail_evt("w_handshake");
            else begin
              e36 = exp_w.pop_front();
              chk("wdata", wdata, e36[35:4]);
              chk("wstrb", {28'd0, wstrb}, {28'd0, e36[3:0]});
            end
          end
          if (bready) chk("bready_after_aw_w", {30'd0, aw_seen, w_seen}, 32'd3);
          chk("addr_ok", {31'd0, data_addr_ok}, {31'd0, (cyc >= busy_until)});
          if (data_data_ok) begin
            aw_seen = 0; w_seen = 0;
            if (exp_ok_data.size() == 0) fail_evt("data_ok_pulse");
            else begin
              chk("data_rdata", data_rdata, exp_ok_data.pop_front());
              chk("data_ok_cycle", cyc, exp_ok_cyc.pop_front());
            end
          end
          pend_ar = arvalid && !arready; prev_ar = {araddr, arsize};
          pend_aw = awvalid && !awready; prev_aw = {awaddr, awsize};
          pend_w  = wvalid && !wready;   prev_w  = {wdata, wstrb};
        end
      end
    end
  end

  int acc_cyc = 0;

  // present one request and hold it until accepted; expectations are pushed after the edge
  task automatic issue(input bit wr, input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] wd_in, input logic [2:0] exp_size,
                       input logic [3:0] exp_strb, input logic [31:0] rval);
    int lat;
    bit ok = 0;
    data_req = 1; data_wr = wr; data_size = size; data_addr = addr; data_wdata = wd_in;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (data_addr_ok) begin ok = 1; acc_cyc = cyc; end
    end
    if (!ok) fail_evt("accept_timeout");
    @(posedge clk); #1;
    data_req = 0;
    if (ok) begin
      if (wr) begin
        lat = 3 + ((awd > wd) ? awd : wd) + bd;
        exp_aw.push_back({addr, exp_size});
        exp_w.push_back({wd_in, exp_strb});
        exp_ok_data.push_back(last_rd);
      end else begin
        lat = 3 + ad + rd;
        rd_val = rval;
        last_rd = rval;
        exp_ar.push_back({addr, exp_size});
        exp_ok_data.push_back(rval);
      end
      exp_ok_cyc.push_back(acc_cyc + lat);
      busy_until = acc_cyc + lat;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_ok_data.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
    if (exp_ok_data.size() != 0) begin
      fail_evt("completion_timeout");
      exp_ok_data.delete(); exp_ok_cyc.delete();
    end
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_arvalid"}, {31'd0, arvalid}, 32'd0);
    chk({tag, "_awvalid"}, {31'd0, awvalid}, 32'd0);
    chk({tag, "_wvalid"},  {31'd0, wvalid},  32'd0);
    chk({tag, "_rready"},  {31'd0, rready},  32'd0);
    chk({tag, "_bready"},  {31'd0, bready},  32'd0);
    chk({tag, "_data_ok"}, {31'd0, data_data_ok}, 32'd0);
    chk({tag, "_addr_ok"}, {31'd0, data_addr_ok}, 32'd1);
    chk({tag, "_rdata"},   data_rdata, 32'd0);
    chk({tag, "_araddr"},  araddr, 32'd0);
    chk({tag, "_awaddr"},  awaddr, 32'd0);
    chk({tag, "_wdata"},   wdata, 32'd0);
    chk({tag, "_arsize"},  {29'd0, arsize}, 32'd0);
    chk({tag, "_wstrb"},   {28'd0, wstrb}, 32'h1);
  endtask

  initial begin
    int first_acc;
    repeat (3) @(posedge clk);
    #1 resetn = 1;
    @(negedge clk);
    chk_reset_outputs("reset");
    mon_en = 1;
    @(posedge clk); #1;

    // word read, zero-wait slave
    issue(0, 2'd2, 32'h1FC0_0004, 32'h0, 3'b010, 4'h0, 32'hDEAD_BEEF);
    wait_idle();

    // byte write, top lane
    issue(1, 2'd0, 32'hBFAF_F003, 32'hAB00_0000, 3'b000, 4'b1000, 32'h0);
    wait_idle();

    // half write, data channel ready three cycles after address channel
    awd = 0; wd = 3; bd = 0;
    issue(1, 2'd1, 32'h8000_0002, 32'h1234_0000, 3'b001, 4'b1100, 32'h0);
    wait_idle();

    // read with stalled address and data channels
    awd = 0; wd = 0; ad = 3; rd = 2;
    issue(0, 2'd2, 32'h0000_1000, 32'h0, 3'b010, 4'h0, 32'h0BAD_F00D);
    wait_idle();

    // read then write with data_req held across
    ad = 0; rd = 0;
    issue(0, 2'd2, 32'h2000_0008, 32'h0, 3'b010, 4'h0, 32'h1357_9BDF);
    first_acc = acc_cyc;
    issue(1, 2'd0, 32'h2000_0001, 32'h0000_5A00, 3'b000, 4'b0010, 32'h0);
    chk("back_to_back_accept", acc_cyc, first_acc + 3);
    wait_idle();

    // reset pulse while the write address/data channels are pending
    awd = 5; wd = 5;
    issue(1, 2'd2, 32'h3000_0000, 32'hFFFF_FFFF, 3'b010, 4'b1111, 32'h0);
    resetn = 0;
    busy_until = cyc + 1;
    exp_aw.delete(); exp_w.delete(); exp_ok_data.delete(); exp_ok_cyc.delete();
    last_rd = 32'd0;
    @(posedge clk); #1;
    resetn = 1;
    @(negedge clk);
    chk_reset_outputs("midreset");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("midreset_no_data_ok", {31'd0, data_data_ok}, 32'd0);
    end
    @(posedge clk); #1;

    // recovery: half read after the abandoned write
    awd = 0; wd = 0;
    issue(0, 2'd1, 32'h0000_0006, 32'h0, 3'b001, 4'h0, 32'hCAFE_0000);
    wait_idle();

    // word write at a word address, data_rdata must keep last read value
    issue(1, 2'd2, 32'h0000_0010, 32'h0102_0304, 3'b010, 4'b1111, 32'h0);
    wait_idle();

    if (exp_ar.size() != 0 || exp_aw.size() != 0 || exp_w.size() != 0)
      fail_evt("leftover_expectations");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
